next_pc_ras_unit: RTL

- Next-PC generator directly upstream of the PC register. Drives its `PC_in` and `PCwrite` inputs.
- Selects among sequential PC+4, ID-stage branch/jal targets, an ID-stage `jr` target predicted by a return-address stack (RAS), and an EX-stage `jr` misprediction redirect.
- Holds the RAS and a mispredict counter. It also emits the IF/ID and ID/EX flush requests.

---
 rtl/next_pc_ras_unit.sv | 133 +++++++++++++
 1 files changed

// File: rtl/next_pc_ras_unit.sv
// next_pc_ras_unit
//   Next-PC generator feeding the PC register. Chooses between sequential
//   PC+4, ID-stage branch/jal targets, an ID-stage jr target predicted by a
//   return-address stack (RAS), and an EX-stage jr misprediction redirect.
//   Also owns the RAS, a saturating mispredict counter and the IF/ID and
//   ID/EX flush requests.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   pc_cur              current fetch PC
//   pc_write            hazard-unit front-end enable (0 = stalled)
//   id_pc               PC of the instruction in ID
//   id_branch_taken/_target, id_jal/_target, id_jr   ID-stage control flow
//   ex_jr, ex_jr_actual, ex_jr_pred, ex_jr_pred_valid  EX-stage jr check
//   pc_next, pc_write_o to the PC register (PC_in / PCwrite)
//   flush_if, flush_id  squash IF/ID and ID/EX registers
//   jr_pred, jr_pred_valid  RAS top of stack, piped along with the ID jr
//   mispredict_cnt      saturating count of EX jr mispredicts
module next_pc_ras_unit #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       pc_cur,
    input  logic              pc_write,
    input  logic [31:0]       id_pc,
    input  logic              id_branch_taken,
    input  logic [31:0]       id_branch_target,
    input  logic              id_jal,
    input  logic [31:0]       id_jal_target,
    input  logic              id_jr,
    input  logic              ex_jr,
    input  logic [31:0]       ex_jr_actual,
    input  logic [31:0]       ex_jr_pred,
    input  logic              ex_jr_pred_valid,
    output logic [31:0]       pc_next,
    output logic              pc_write_o,
    output logic              flush_if,
    output logic              flush_id,
    output logic [31:0]       jr_pred,
    output logic              jr_pred_valid,
    output logic [CNT_W-1:0]  mispredict_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

    logic [31:0]      stack [DEPTH];
    logic [PTR_W-1:0] tos;
    logic [OCC_W-1:0] count;

    logic             ex_mis;
    logic             id_fire;
    logic             do_push;
    logic             do_pop;
    logic [PTR_W-1:0] tos_m1;

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + CNT_W'(1);
    endfunction

    // Occupancy increment clamped at DEPTH; a full stack overwrites its
    // oldest entry while the occupancy stays at DEPTH.
    function automatic logic [OCC_W-1:0] occ_inc(input logic [OCC_W-1:0] v);
        if (v == OCC_FULL) begin
            return v;
        end
        return v + OCC_W'(1);
    endfunction

    assign ex_mis  = ex_jr & (~ex_jr_pred_valid | (ex_jr_actual != ex_jr_pred));
    // ID is only allowed to touch the RAS when it actually advances and is
    // not on a wrong path being squashed by an EX redirect.
    assign id_fire = pc_write & ~ex_mis;
    assign do_push = id_fire & id_jal;
    assign do_pop  = id_fire & id_jr & ~id_jal & (count != '0);
    assign tos_m1  = tos - PTR_W'(1);

    assign jr_pred_valid = (count != '0);
    assign jr_pred       = jr_pred_valid ? stack[tos_m1] : 32'h0;

    always_comb begin
        pc_next  = pc_cur + 32'd4;
        flush_if = 1'b0;
        if (ex_mis) begin
            pc_next  = ex_jr_actual;
            flush_if = 1'b1;
        end else if (id_branch_taken) begin
            pc_next  = id_branch_target;
            flush_if = 1'b1;
        end else if (id_jal) begin
            pc_next  = id_jal_target;
            flush_if = 1'b1;
        end else if (id_jr && jr_pred_valid) begin
            pc_next  = jr_pred;
            flush_if = 1'b1;
        end
    end

    assign flush_id   = ex_mis;
    // An EX redirect must land even while the front end is stalled.
    assign pc_write_o = pc_write | ex_mis;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stack[i] <= 32'h0;
            end
            tos            <= '0;
            count          <= '0;
            mispredict_cnt <= '0;
        end else begin
            if (do_push) begin
                stack[tos] <= id_pc + 32'd4;
                tos        <= tos + PTR_W'(1);
                count      <= occ_inc(count);
            end else if (do_pop) begin
                tos   <= tos_m1;
                count <= count - OCC_W'(1);
            end
            if (ex_mis) begin
                mispredict_cnt <= sat_inc(mispredict_cnt);
            end
        end
    end

endmodule
